// File: rtl/uart_rx.sv
// uart_rx: serial receiver for one start slot, 8 data slots (LSB first),
// one parity slot and one or two stop slots, sampled mid-slot.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   rxd      serial line, idle high (synchronized internally to rxs)
//   par      parity mode: 00 even (XOR), 11 odd (XNOR), 01/10 not checked
//   dnum     1 = 7 data bits (slot 8 discarded), 0 = 8 data bits
//   snum     1 = one stop slot, 0 = two stop slots
//   data     last received character
//   valid    one-cycle pulse when data/par_err/frm_err update
//   par_err  parity mismatch for the last frame
//   frm_err  a stop slot was sampled low in the last frame
//   busy     high from start detection until the FSM is back in IDLE
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] par,
    input  logic       dnum,
    input  logic       snum,
    output logic [7:0] data,
    output logic       valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       busy
);

    localparam int         HALF      = CLKS_PER_BIT / 2;
    localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = (HALF > 0) ? 8'(HALF - 1) : 8'd0;
    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             fill_q;
    logic                   rxs;
    logic                   primed;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] pmode_q, pmode_d;
    logic       dmode_q, dmode_d;
    logic       smode_q, smode_d;
    logic       pbit_q, pbit_d;
    logic       serr_q, serr_d;
    logic       armed_q, armed_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic       tick;
    logic       half_tick;
    logic       finish;
    logic [7:0] char_w;
    logic       par_exp;
    logic       par_chk;

    // Synchronizer. fill_q tracks how many real rxd samples have entered
    // the chain since reset, so the reset-value ones are never mistaken
    // for an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            fill_q <= '0;
        end else begin
            sync_q[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (fill_q != FILL_DONE) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign primed = (fill_q == FILL_DONE);

    assign tick      = (cnt_q == TICK_LAST);
    assign half_tick = (cnt_q == HALF_LAST);

    // In 7-bit mode the eighth sampled slot is dropped and bit 7 reads 0;
    // parity is taken over that forced value.
    assign char_w  = dmode_q ? {1'b0, shreg_q[6:0]} : shreg_q;
    assign par_exp = (pmode_q == 2'b11) ? ~(^char_w) : (^char_w);
    assign par_chk = (pmode_q == 2'b00) || (pmode_q == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            pmode_q <= '0;
            dmode_q <= 1'b0;
            smode_q <= 1'b0;
            pbit_q  <= 1'b0;
            serr_q  <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            pmode_q <= pmode_d;
            dmode_q <= dmode_d;
            smode_q <= smode_d;
            pbit_q  <= pbit_d;
            serr_q  <= serr_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pmode_d = pmode_q;
        dmode_d = dmode_q;
        smode_d = smode_q;
        pbit_d  = pbit_q;
        serr_d  = serr_q;
        armed_d = armed_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        finish  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A start needs a high line first; this rejects a line
                // left low after a framing error.
                armed_d = armed_q | (rxs & primed);
                if (armed_q && !rxs) begin
                    pmode_d = par;
                    dmode_d = dnum;
                    smode_d = snum;
                    cnt_d   = '0;
                    bit_d   = '0;
                    armed_d = 1'b0;
                    // With a one-cycle slot the detection sample is
                    // already the mid-slot start sample.
                    state_d = (HALF == 0) ? DATA : START;
                end
            end
            START: begin
                if (half_tick) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                        armed_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = '0;
                    pbit_d  = rxs;
                    state_d = STOP1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP1: begin
                if (tick) begin
                    cnt_d  = '0;
                    serr_d = ~rxs;
                    if (!smode_q) begin
                        state_d = STOP2;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP2: begin
                if (tick) begin
                    cnt_d  = '0;
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = char_w;
            perr_d  = par_chk & (pbit_q != par_exp);
            ferr_d  = ~rxs | ((state_q == STOP2) & serr_q);
            // A good final stop arms IDLE so a back-to-back start is
            // caught on the very next cycle.
            armed_d = rxs;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign par_err = perr_q;
    assign frm_err = ferr_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, giving clk cycles per serial bit slot; legal range 1..255.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in the rxd synchronizer; legal range 1..3.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rxd  input  1  serial line; idle high.
REQ-006 SHALL have port par  input  2  parity mode: 00 expects XOR of data slots, 11 expects XNOR, 01/10 parity slot present but unchecked.
REQ-007 SHALL have port dnum  input  1  1 = 7-bit data, 0 = 8-bit data.
REQ-008 SHALL have port snum  input  1  0 = two stop slots, 1 = one stop slot.
REQ-009 SHALL have port data  output  8  last received character.
REQ-010 SHALL have port valid  output  1  one-cycle pulse when data and error flags update.
REQ-011 SHALL have port par_err  output  1  parity mismatch for the last frame.
REQ-012 SHALL have port frm_err  output  1  stop slot sampled low in the last frame.
REQ-013 SHALL have port busy  output  1  high from start detection until return to IDLE.

Function
REQ-014 SHALL pass rxd through SYNC_STAGES flops reset to 1; all detection uses the synchronized signal rxs.
REQ-015 Frame format SHALL be: start slot (0), 8 data slots LSB first, 1 parity slot, then 1 or 2 stop slots (1).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-017 In IDLE, rxs=0 SHALL move to START and SHALL capture par, dnum and snum for the whole frame.
REQ-018 START SHALL wait floor(CLKS_PER_BIT/2) cycles and then re-sample rxs.
- rxs=1 (glitch): return to IDLE, no valid.
- rxs=0: go to DATA.
- With CLKS_PER_BIT=1 the sample is taken in the detection cycle.
REQ-019 Each later slot SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample, using a bit counter of 0..7 in DATA.
REQ-020 In 7-bit mode, slot 8 SHALL be sampled and discarded, and data[7] SHALL be 0.
REQ-021 Expected parity SHALL be computed over data[7:0] as received with data[7] forced per REQ-020. par_err SHALL be 1 only if the mode is 00 or 11 and the sampled parity differs.
REQ-022 After STOP1, STOP2 SHALL follow only if the captured snum=0. frm_err SHALL be 1 if any stop sample is 0.
REQ-023 In the cycle after the final stop sample:
- valid SHALL be 1 for exactly one cycle.
- data, par_err and frm_err SHALL update.
- The FSM SHALL be in IDLE.
REQ-024 data, par_err and frm_err SHALL hold their values until the next valid.
REQ-025 A start bit immediately following the last stop slot (back-to-back frames) SHALL be detected with no lost cycle.
REQ-026 Frame latency from the start edge at rxd to valid SHALL equal SYNC_STAGES + floor(CLKS_PER_BIT/2) + (N_slots-1)*CLKS_PER_BIT + 1 cycles, where N_slots = 11 or 12.
REQ-027 Changes on par, dnum or snum mid-frame SHALL NOT affect the frame in progress.
REQ-028 A frame with frm_err=1 SHALL still deliver data and valid. The FSM SHALL return to IDLE and wait for rxs=1 then 0 before the next start.

Reset
REQ-029 On rst=1, asynchronously:
- state=IDLE, counters=0, synchronizer flops=1.
- data=8'h00, valid=0, par_err=0, frm_err=0, busy=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no valid pulse. Reception SHALL restart only on a new falling edge after rst deasserts.

Verification
REQ-031 CLKS_PER_BIT=1, par=11, dnum=0, snum=1, sending 0xA5 (slots 0,1,0,1,0,0,1,0,1,1,1) SHALL yield data=A5, valid pulse, par_err=0, frm_err=0.
REQ-032 Same setup, par=00, with parity slot 1 for 0x3C SHALL yield data=3C, par_err=1. With par=01 and the same stream, par_err=0.
REQ-033 dnum=1, snum=0, sending 0x55 (slot 8 = 0, two stop slots) SHALL yield data=55, valid 13+SYNC_STAGES-1 cycles after the start edge. A second stop slot driven 0 SHALL yield frm_err=1.
REQ-034 CLKS_PER_BIT=16, a 3-cycle low glitch on idle rxd SHALL produce no valid and busy SHALL drop within 8 cycles. A following full frame of 0x81 SHALL be received correctly.
REQ-035 Two back-to-back frames 0x12 then 0x34 at CLKS_PER_BIT=1 SHALL produce two valid pulses 11 cycles apart (snum=1) with the correct data.
REQ-036 rst pulsed during data slot 4 SHALL give all outputs at reset values, no valid, and correct reception of the next frame.
